// File: rtl/memory_stage_pkg.sv
// Shared Y86-64 constants, M-register layout and access-class helpers for the memory stage.
package memory_stage_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } dmem_state_e;

  typedef struct packed {
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        cnd;
  } m_reg_t;

  localparam m_reg_t M_BUBBLE = '{
    icode: I_NOP,
    stat:  STAT_AOK,
    val_e: '0,
    val_a: '0,
    dst_e: RNONE,
    dst_m: RNONE,
    cnd:   1'b0
  };

  function automatic logic is_read(input logic [3:0] icode);
    return (icode == I_MRMOVQ) || (icode == I_POPQ) || (icode == I_RET);
  endfunction

  function automatic logic is_write(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_PUSHQ) || (icode == I_CALL);
  endfunction

  // Stack pops read at the old stack pointer; everything else addresses through valE.
  function automatic logic uses_val_a_addr(input logic [3:0] icode);
    return (icode == I_POPQ) || (icode == I_RET);
  endfunction

endpackage

// File: rtl/memory_stage_dmem_access_fsm.sv
// Data-memory handshake sequencer: IDLE/REQ/WAIT over req/gnt/rvalid, producing done and the stall request.
module dmem_access_fsm
  import memory_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start,
  input  logic        write,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic        gnt,
  input  logic        rvalid,
  output logic        req,
  output logic        we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        done,
  output logic        busy
);

  dmem_state_e state;
  logic        issue;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start)  state <= gnt ? ST_WAIT : ST_REQ;
        ST_REQ:  if (gnt)    state <= ST_WAIT;
        ST_WAIT: if (rvalid) state <= ST_IDLE;
        default:             state <= ST_IDLE;
      endcase
    end
  end

  // The request goes out in the same cycle the access appears in M so a
  // same-cycle grant gives the two-cycle minimum access.
  always_comb begin
    issue     = (state == ST_IDLE) && start;
    req       = issue || (state == ST_REQ);
    done      = (state == ST_WAIT) && rvalid;
    busy      = issue || (state == ST_REQ) || ((state == ST_WAIT) && !rvalid);
    we        = req && write;
    mem_addr  = addr;
    mem_wdata = wdata;
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register, data-memory access and m_stat.
// Build option MEM_ALIGN_CHECK_EN: unaligned accesses report ADR and never reach memory.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter logic [63:0] ADDR_LIMIT = 64'h0000_0000_0001_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  E_icode_i,
  input  logic [63:0] E_valA_i,
  input  logic [3:0]  E_dstM_i,
  input  logic [2:0]  E_stat_i,
  input  logic [63:0] e_valE_i,
  input  logic [3:0]  e_dstE_i,
  input  logic        e_cnd_i,
  input  logic        M_bubble_i,
  output logic [3:0]  M_icode_o,
  output logic [63:0] M_valE_o,
  output logic [3:0]  M_dstE_o,
  output logic [3:0]  M_dstM_o,
  output logic        M_cnd_o,
  output logic [63:0] m_valM_o,
  output logic [2:0]  m_stat_o,
  output logic        m_busy_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  input  logic        dmem_err_i
);

  m_reg_t      m_q;
  m_reg_t      m_d;
  logic        busy;
  logic        done;
  logic        rd_acc;
  logic        wr_acc;
  logic [63:0] addr;
  logic        misalign;
  logic        addr_bad;
  logic        start;

  always_comb begin
    m_d = M_BUBBLE;
    if (!M_bubble_i) begin
      m_d.icode = E_icode_i;
      m_d.stat  = E_stat_i;
      m_d.val_e = e_valE_i;
      m_d.val_a = E_valA_i;
      m_d.dst_e = ((E_icode_i == I_CMOVXX) && !e_cnd_i) ? RNONE : e_dstE_i;
      m_d.dst_m = E_dstM_i;
      m_d.cnd   = e_cnd_i;
    end
  end

  // M only advances when no access is outstanding; the done cycle drops busy so it advances then.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_q <= M_BUBBLE;
    end else if (!busy) begin
      m_q <= m_d;
    end
  end

  assign rd_acc = is_read(m_q.icode);
  assign wr_acc = is_write(m_q.icode);
  assign addr   = uses_val_a_addr(m_q.icode) ? m_q.val_a : m_q.val_e;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (addr[2:0] != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  assign addr_bad = (rd_acc || wr_acc) && ((addr >= ADDR_LIMIT) || misalign);
  assign start    = (rd_acc || wr_acc) && !addr_bad && (m_q.stat == STAT_AOK);

  dmem_access_fsm u_fsm (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start     (start),
    .write     (wr_acc),
    .addr      (addr),
    .wdata     (m_q.val_a),
    .gnt       (dmem_gnt_i),
    .rvalid    (dmem_rvalid_i),
    .req       (dmem_req_o),
    .we        (dmem_we_o),
    .mem_addr  (dmem_addr_o),
    .mem_wdata (dmem_wdata_o),
    .done      (done),
    .busy      (busy)
  );

  assign m_busy_o  = busy;
  assign m_stat_o  = (addr_bad || (done && dmem_err_i)) ? STAT_ADR : m_q.stat;
  assign m_valM_o  = (done && rd_acc && !dmem_err_i) ? dmem_rdata_i : '0;

  assign M_icode_o = m_q.icode;
  assign M_valE_o  = m_q.val_e;
  assign M_dstE_o  = m_q.dst_e;
  assign M_dstM_o  = m_q.dst_m;
  assign M_cnd_o   = m_q.cnd;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: random instruction stream, memory responder and retire-time checks.
module tb_memory_stage;

  localparam logic [63:0] LIMIT = 64'h0000_0000_0001_0000;
  localparam logic [3:0] NOP = 4'h1, CMOV = 4'h2, IRMOV = 4'h3, RMMOV = 4'h4, MRMOV = 4'h5;
  localparam logic [3:0] OPQ = 4'h6, JXX = 4'h7, CALL = 4'h8, RET = 4'h9, PUSH = 4'hA, POP = 4'hB;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam int NCYC = 700;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  E_icode_i, E_dstM_i, e_dstE_i;
  logic [63:0] E_valA_i, e_valE_i;
  logic [2:0]  E_stat_i;
  logic        e_cnd_i, M_bubble_i;
  logic [3:0]  M_icode_o, M_dstE_o, M_dstM_o;
  logic [63:0] M_valE_o, m_valM_o, dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic        M_cnd_o, m_busy_o, dmem_req_o, dmem_we_o;
  logic [2:0]  m_stat_o;
  logic        dmem_gnt_i, dmem_rvalid_i, dmem_err_i;

  memory_stage #(.ADDR_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .E_icode_i(E_icode_i), .E_valA_i(E_valA_i), .E_dstM_i(E_dstM_i), .E_stat_i(E_stat_i),
    .e_valE_i(e_valE_i), .e_dstE_i(e_dstE_i), .e_cnd_i(e_cnd_i), .M_bubble_i(M_bubble_i),
    .M_icode_o(M_icode_o), .M_valE_o(M_valE_o), .M_dstE_o(M_dstE_o), .M_dstM_o(M_dstM_o),
    .M_cnd_o(M_cnd_o), .m_valM_o(m_valM_o), .m_stat_o(m_stat_o), .m_busy_o(m_busy_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [3:0]  dst_e, dst_m;
    logic        cnd;
    logic [2:0]  stat;
    logic [63:0] val_m;
    int unsigned dur;
  } exp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr, wdata, rdata;
    int unsigned gd, rd;
    logic        err;
  } mem_t;

  exp_t sb_q[$];
  mem_t mem_q[$];
  int   errors = 0, checks = 0;
  bit   mon_en = 1'b0, resp_en = 1'b0;

  bit          f_use;
  int unsigned f_gd, f_rd;
  logic        f_err;
  logic [63:0] f_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t bubble_exp();
    exp_t e;
    e.icode = NOP; e.val_e = '0; e.dst_e = RNONE; e.dst_m = RNONE;
    e.cnd = 1'b0; e.stat = AOK; e.val_m = '0; e.dur = 1;
    return e;
  endfunction

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 8))
      0: return LIMIT;
      1: return LIMIT - 64'd8;
      2: return {$urandom, $urandom};
      3: return 64'h1F8;
      4: return {48'h0, 16'($urandom)};
      5: return LIMIT - 64'd1;
      default: return {48'h0, 13'($urandom), 3'b000};
    endcase
  endfunction

  task automatic set_instr(input logic [3:0] ic, input logic [63:0] va, input logic [63:0] ve,
                           input logic [3:0] de, input logic [3:0] dm, input logic c, input logic [2:0] st);
    M_bubble_i = 1'b0; E_icode_i = ic; E_valA_i = va; e_valE_i = ve;
    e_dstE_i = de; E_dstM_i = dm; e_cnd_i = c; E_stat_i = st; f_use = 1'b0;
  endtask

  task automatic set_mem(input int unsigned gd, input int unsigned rd, input logic err, input logic [63:0] rdata);
    f_use = 1'b1; f_gd = gd; f_rd = rd; f_err = err; f_rdata = rdata;
  endtask

  task automatic drive_directed(input int idx);
    case (idx)
      0: set_instr(IRMOV, 64'h0, 64'h10, 4'd3, RNONE, 1'b1, AOK);
      1: set_instr(CMOV, 64'h7, 64'h99, 4'd5, RNONE, 1'b0, AOK);
      2: begin set_instr(MRMOV, 64'h0, 64'h100, RNONE, 4'd2, 1'b1, AOK); set_mem(2, 1, 1'b0, 64'hDEAD); end
      3: set_instr(RMMOV, 64'h55, LIMIT, RNONE, RNONE, 1'b1, AOK);
      4: begin set_instr(PUSH, 64'hCAFE, 64'h1F8, 4'd4, RNONE, 1'b1, AOK); set_mem(0, 1, 1'b1, 64'h0); end
      5: begin set_instr(POP, 64'h208, 64'h210, 4'd4, 4'd6, 1'b1, AOK); set_mem(1, 2, 1'b0, 64'h1234_5678); end
      default: begin set_instr(CALL, 64'h4321, 64'h300, 4'd4, RNONE, 1'b1, AOK); set_mem(0, 1, 1'b0, 64'h0); end
    endcase
  endtask

  task automatic drive_random();
    logic [3:0] ic;
    case ($urandom_range(0, 10))
      0: ic = NOP;   1: ic = CMOV;  2: ic = IRMOV; 3: ic = RMMOV;
      4: ic = MRMOV; 5: ic = OPQ;   6: ic = JXX;   7: ic = CALL;
      8: ic = RET;   9: ic = PUSH;  default: ic = POP;
    endcase
    set_instr(ic, rand_addr(), rand_addr(), 4'($urandom), 4'($urandom), 1'($urandom),
              ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? HLT : INS) : AOK);
    M_bubble_i = ($urandom_range(0, 9) == 0);
  endtask

  // Reference: what the instruction currently on the E/e inputs must look like when it leaves M.
  task automatic push_expect();
    exp_t        e;
    mem_t        m;
    logic        rd, wr, bad, go;
    logic [63:0] addr;
    if (M_bubble_i) begin
      e = bubble_exp();
    end else begin
      rd   = (E_icode_i == MRMOV) || (E_icode_i == POP) || (E_icode_i == RET);
      wr   = (E_icode_i == RMMOV) || (E_icode_i == PUSH) || (E_icode_i == CALL);
      addr = (E_icode_i == POP || E_icode_i == RET) ? E_valA_i : e_valE_i;
      bad  = (rd || wr) && (addr >= LIMIT || (ALIGN_EN && addr[2:0] != 3'b000));
      go   = (rd || wr) && !bad && (E_stat_i == AOK);
      e.icode = E_icode_i;
      e.val_e = e_valE_i;
      e.dst_e = (E_icode_i == CMOV && !e_cnd_i) ? RNONE : e_dstE_i;
      e.dst_m = E_dstM_i;
      e.cnd   = e_cnd_i;
      e.stat  = bad ? ADR : E_stat_i;
      e.val_m = '0;
      e.dur   = 1;
      if (go) begin
        m.we = wr; m.addr = addr; m.wdata = E_valA_i;
        if (f_use) begin
          m.gd = f_gd; m.rd = f_rd; m.err = f_err; m.rdata = f_rdata;
        end else begin
          m.gd = $urandom_range(0, 2); m.rd = $urandom_range(1, 3);
          m.err = ($urandom_range(0, 5) == 0); m.rdata = {$urandom, $urandom};
        end
        mem_q.push_back(m);
        if (m.err) e.stat = ADR;
        else if (rd) e.val_m = m.rdata;
        e.dur = m.gd + m.rd + 1;
      end
    end
    sb_q.push_back(e);
  endtask

  // Monitor: every cycle without a stall retires whatever is in M.
  initial begin : monitor
    exp_t        e;
    int unsigned held = 0;
    forever begin
      @(negedge clk_i); #2;
      if (mon_en) begin
        if (!m_busy_o) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 64'(sb_q.size()), 64'd1);
          end else begin
            e = sb_q.pop_front();
            check("M_icode", M_icode_o, e.icode);
            check("M_valE", M_valE_o, e.val_e);
            check("M_dstE", M_dstE_o, e.dst_e);
            check("M_dstM", M_dstM_o, e.dst_m);
            check("M_cnd", M_cnd_o, e.cnd);
            check("m_stat", m_stat_o, e.stat);
            check("m_valM", m_valM_o, e.val_m);
            check("cycles_in_M", held + 1, e.dur);
          end
          held = 0;
        end else begin
          held++;
          if (held > 60) begin
            check("stall_timeout", 64'(held), 64'd0);
            held = 0;
          end
        end
      end else begin
        held = 0;
      end
    end
  end

  // Memory responder: replays the delays/data chosen when each access was issued.
  initial begin : responder
    mem_t m;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = '0;
    @(negedge clk_i);
    forever begin
      if (resp_en && dmem_req_o) begin
        if (mem_q.size() == 0) begin
          check("unexpected_req", dmem_req_o, 1'b0);
          @(negedge clk_i);
        end else begin
          m = mem_q.pop_front();
          check("dmem_we", dmem_we_o, m.we);
          check("dmem_addr", dmem_addr_o, m.addr);
          if (m.we) check("dmem_wdata", dmem_wdata_o, m.wdata);
          repeat (m.gd) begin
            @(negedge clk_i);
            check("req_held", dmem_req_o, 1'b1);
            check("addr_held", dmem_addr_o, m.addr);
          end
          dmem_gnt_i = 1'b1;
          @(negedge clk_i);
          dmem_gnt_i = 1'b0;
          check("req_after_gnt", dmem_req_o, 1'b0);
          repeat (m.rd - 1) @(negedge clk_i);
          dmem_rvalid_i = 1'b1; dmem_err_i = m.err; dmem_rdata_i = m.rdata;
          @(negedge clk_i);
          dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = {$urandom, $urandom};
        end
      end else begin
        @(negedge clk_i);
      end
    end
  end

  initial begin : stimulus
    bit acc;
    int nxt = 0;
    rst_n_i = 1'b0;
    set_instr(NOP, '0, '0, RNONE, RNONE, 1'b0, AOK);
    M_bubble_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_M_icode", M_icode_o, NOP);
    check("rst_M_dstE", M_dstE_o, RNONE);
    check("rst_M_dstM", M_dstM_o, RNONE);
    check("rst_M_valE", M_valE_o, 64'h0);
    check("rst_M_cnd", M_cnd_o, 1'b0);
    check("rst_m_stat", m_stat_o, AOK);
    check("rst_req", dmem_req_o, 1'b0);
    check("rst_busy", m_busy_o, 1'b0);

    drive_directed(0);
    sb_q.push_back(bubble_exp());
    rst_n_i = 1'b1; mon_en = 1'b1; resp_en = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk_i); #2;
      acc = !m_busy_o;
      if (acc) push_expect();
      @(posedge clk_i); #1;
      if (acc) begin
        nxt++;
        if (nxt < 7) drive_directed(nxt);
        else if (cyc < NCYC - 30) drive_random();
        else begin set_instr(NOP, '0, '0, RNONE, RNONE, 1'b0, AOK); M_bubble_i = 1'b1; end
      end
    end
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    check("sb_q_drained", 64'(sb_q.size()), 64'd1);

    // Reset during WAIT must abort the read and ignore the late completion.
    mon_en = 1'b0; resp_en = 1'b0;
    set_instr(POP, 64'h200, 64'h208, 4'd4, 4'd7, 1'b1, AOK);
    @(posedge clk_i); #1;
    check("abort_req_issue", dmem_req_o, 1'b1);
    check("abort_addr", dmem_addr_o, 64'h200);
    check("abort_we", dmem_we_o, 1'b0);
    dmem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0;
    check("abort_wait_busy", m_busy_o, 1'b1);
    check("abort_wait_req", dmem_req_o, 1'b0);
    M_bubble_i = 1'b1;
    #2 rst_n_i = 1'b0;
    #1;
    check("abort_rst_req", dmem_req_o, 1'b0);
    check("abort_rst_busy", m_busy_o, 1'b0);
    check("abort_rst_icode", M_icode_o, NOP);
    check("abort_rst_dstM", M_dstM_o, RNONE);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    dmem_rvalid_i = 1'b1; dmem_err_i = 1'b1; dmem_rdata_i = 64'hBAD;
    #1;
    check("late_rvalid_busy", m_busy_o, 1'b0);
    check("late_rvalid_valM", m_valM_o, 64'h0);
    check("late_rvalid_stat", m_stat_o, AOK);
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
    check("late_rvalid_req", dmem_req_o, 1'b0);
    check("late_rvalid_icode", M_icode_o, NOP);
    check("late_rvalid_busy2", m_busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
